// File: rtl/trig_lut_arbiter_if.sv
// Bundles the two requester handshakes, the LUT-facing angle/data signals and
// the shared response bus of trig_lut_arbiter.
interface trig_lut_arbiter_if #(
  parameter int WIDTH_TRIG = 20,
  parameter int ANGLE_BITS = 10
);
  logic                         req0_valid;
  logic [ANGLE_BITS-1:0]        req0_angle;
  logic                         req0_ready;
  logic                         req1_valid;
  logic [ANGLE_BITS-1:0]        req1_angle;
  logic                         req1_ready;

  logic [ANGLE_BITS-1:0]        lut_angle;
  logic signed [WIDTH_TRIG-1:0] lut_sin;
  logic signed [WIDTH_TRIG-1:0] lut_cos;
  logic signed [WIDTH_TRIG-1:0] lut_tan;
  logic signed [WIDTH_TRIG-1:0] lut_atan;

  logic                         rsp0_valid;
  logic                         rsp1_valid;
  logic signed [WIDTH_TRIG-1:0] rsp_sin;
  logic signed [WIDTH_TRIG-1:0] rsp_cos;
  logic signed [WIDTH_TRIG-1:0] rsp_tan;
  logic signed [WIDTH_TRIG-1:0] rsp_atan;
  logic                         busy;

  // The arbiter side.
  modport slave (
    input  req0_valid, req0_angle, req1_valid, req1_angle,
    input  lut_sin, lut_cos, lut_tan, lut_atan,
    output req0_ready, req1_ready, lut_angle,
    output rsp0_valid, rsp1_valid, rsp_sin, rsp_cos, rsp_tan, rsp_atan, busy
  );

  // The requester/LUT environment side.
  modport master (
    output req0_valid, req0_angle, req1_valid, req1_angle,
    output lut_sin, lut_cos, lut_tan, lut_atan,
    input  req0_ready, req1_ready, lut_angle,
    input  rsp0_valid, rsp1_valid, rsp_sin, rsp_cos, rsp_tan, rsp_atan, busy
  );
endinterface

// File: rtl/trig_lut_arbiter.sv
// Round-robin sharing of one trig LUT between the raycaster (0) and the player
// unit (1); a tag pipeline matched to the LUT latency routes results back.
module trig_lut_arbiter #(
  parameter int WIDTH_TRIG  = 20,
  parameter int ANGLE_BITS  = 10,
  parameter int LUT_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  trig_lut_arbiter_if.slave     bus
);

  localparam int STAGES = LUT_LATENCY + 1;

  logic                  ptr_q, ptr_d;
  logic [ANGLE_BITS-1:0] lut_angle_q, lut_angle_d;
  logic [STAGES-1:0]     tag_valid_q, tag_valid_d;
  logic [STAGES-1:0]     tag_id_q, tag_id_d;
  logic                  rsp0_valid_q, rsp0_valid_d;
  logic                  rsp1_valid_q, rsp1_valid_d;
  logic [WIDTH_TRIG-1:0] rsp_sin_q, rsp_sin_d;
  logic [WIDTH_TRIG-1:0] rsp_cos_q, rsp_cos_d;
  logic [WIDTH_TRIG-1:0] rsp_tan_q, rsp_tan_d;
  logic [WIDTH_TRIG-1:0] rsp_atan_q, rsp_atan_d;

  logic grant0, grant1;
  logic accept, accept_id;
  logic final_valid, final_id;

  // ptr_q holds the id granted last, so on a tie the other requester wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant0 = ptr_q;
      grant1 = !ptr_q;
    end else begin
      grant0 = bus.req0_valid;
      grant1 = bus.req1_valid;
    end
  end

  assign accept      = grant0 | grant1;
  assign accept_id   = grant1;
  assign final_valid = tag_valid_q[STAGES-1];
  assign final_id    = tag_id_q[STAGES-1];

  always_comb begin
    ptr_d       = ptr_q;
    lut_angle_d = lut_angle_q;
    if (accept) begin
      ptr_d       = accept_id;
      lut_angle_d = accept_id ? bus.req1_angle : bus.req0_angle;
    end

    tag_valid_d    = '0;
    tag_id_d       = '0;
    tag_valid_d[0] = accept;
    tag_id_d[0]    = accept_id;
    for (int i = 1; i < STAGES; i++) begin
      tag_valid_d[i] = tag_valid_q[i-1];
      tag_id_d[i]    = tag_id_q[i-1];
    end

    // The final-stage tag lines up with valid LUT data for its own angle.
    rsp0_valid_d = final_valid && !final_id;
    rsp1_valid_d = final_valid && final_id;
    rsp_sin_d    = rsp_sin_q;
    rsp_cos_d    = rsp_cos_q;
    rsp_tan_d    = rsp_tan_q;
    rsp_atan_d   = rsp_atan_q;
    if (final_valid) begin
      rsp_sin_d  = bus.lut_sin;
      rsp_cos_d  = bus.lut_cos;
      rsp_tan_d  = bus.lut_tan;
      rsp_atan_d = bus.lut_atan;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= 1'b1;
      lut_angle_q  <= '0;
      tag_valid_q  <= '0;
      tag_id_q     <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp_sin_q    <= '0;
      rsp_cos_q    <= '0;
      rsp_tan_q    <= '0;
      rsp_atan_q   <= '0;
    end else begin
      ptr_q        <= ptr_d;
      lut_angle_q  <= lut_angle_d;
      tag_valid_q  <= tag_valid_d;
      tag_id_q     <= tag_id_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp_sin_q    <= rsp_sin_d;
      rsp_cos_q    <= rsp_cos_d;
      rsp_tan_q    <= rsp_tan_d;
      rsp_atan_q   <= rsp_atan_d;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.lut_angle  = lut_angle_q;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp_sin    = rsp_sin_q;
  assign bus.rsp_cos    = rsp_cos_q;
  assign bus.rsp_tan    = rsp_tan_q;
  assign bus.rsp_atan   = rsp_atan_q;
  assign bus.busy       = |tag_valid_q;

endmodule

// File: tb/tb_trig_lut_arbiter.sv
// Drives three arbiters (LUT latency 0, 1 and 4) with shared requester stimulus
// and compares every output against a transaction-level reference model.
module tb_trig_lut_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0;
  logic [9:0] req0_angle = '0;
  logic       req1_valid = 1'b0;
  logic [9:0] req1_angle = '0;

  always #5 clk = ~clk;

  // Stand-in LUT contents: fixed codes at the boundary angles, a hash elsewhere.
  function automatic logic [79:0] lut_f(input logic [9:0] a);
    logic [19:0] s, c, t, at;
    s  = {a, a ^ 10'h2A5};
    c  = {~a, a};
    t  = {a ^ 10'h15A, ~a};
    at = {a[4:0], a, a[9:5]};
    case (a)
      10'd0:   begin s = 20'h00000; c = 20'h10000; t = 20'h00000; at = 20'h7FFFF; end
      10'd128: begin s = 20'h0B505; c = 20'h0B505; t = 20'h10000; at = 20'h0C90F; end
      10'd256: begin s = 20'h10000; c = 20'h00000; t = 20'h7FFFF; at = 20'h00000; end
      10'd512: begin s = 20'h00000; c = 20'hF0000; t = 20'h00000; at = 20'h80000; end
      10'd768: begin s = 20'hF0000; c = 20'h00000; t = 20'h80000; at = 20'h00000; end
      default: ;
    endcase
    return {s, c, t, at};
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : 4;
  endfunction

  logic [2:0]       o_r0, o_r1, o_p0, o_p1, o_busy;
  logic [2:0][9:0]  o_ang;
  logic [2:0][79:0] o_rsp;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int LAT = (g == 0) ? 0 : (g == 1) ? 1 : 4;
    trig_lut_arbiter_if #(.WIDTH_TRIG(20), .ANGLE_BITS(10)) bus_i ();
    logic [9:0]  pipe [1:4];
    logic [9:0]  lut_sel;
    logic [79:0] lut_word;

    always @(posedge clk) begin
      pipe[1] <= bus_i.lut_angle;
      for (int i = 2; i <= 4; i++) pipe[i] <= pipe[i-1];
    end

    assign lut_sel  = (LAT == 0) ? bus_i.lut_angle : pipe[(LAT == 0) ? 1 : LAT];
    assign lut_word = lut_f(lut_sel);
    assign bus_i.lut_sin    = lut_word[79:60];
    assign bus_i.lut_cos    = lut_word[59:40];
    assign bus_i.lut_tan    = lut_word[39:20];
    assign bus_i.lut_atan   = lut_word[19:0];
    assign bus_i.req0_valid = req0_valid;
    assign bus_i.req0_angle = req0_angle;
    assign bus_i.req1_valid = req1_valid;
    assign bus_i.req1_angle = req1_angle;

    trig_lut_arbiter #(.WIDTH_TRIG(20), .ANGLE_BITS(10), .LUT_LATENCY(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_i)
    );

    assign o_r0[g]   = bus_i.req0_ready;
    assign o_r1[g]   = bus_i.req1_ready;
    assign o_p0[g]   = bus_i.rsp0_valid;
    assign o_p1[g]   = bus_i.rsp1_valid;
    assign o_busy[g] = bus_i.busy;
    assign o_ang[g]  = bus_i.lut_angle;
    assign o_rsp[g]  = {bus_i.rsp_sin, bus_i.rsp_cos, bus_i.rsp_tan, bus_i.rsp_atan};
  end

  // Reference model: a log of accepted lookups and, per latency, the next one due.
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          nacc  = 0;
  int          acc_cyc [0:2047];
  bit          acc_id  [0:2047];
  logic [9:0]  acc_ang [0:2047];
  int          head    [0:2];
  bit          last_id;
  logic [9:0]  exp_ang;
  logic [79:0] exp_rsp [0:2];
  bit          exp_p0  [0:2];
  bit          exp_p1  [0:2];
  bit          exp_busy[0:2];
  bit          er0, er1, acc0, acc1;

  task automatic checkOutput(input string tag, input logic [79:0] got, input logic [79:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic resetModel();
    last_id = 1'b1;
    exp_ang = '0;
    for (int k = 0; k < 3; k++) begin
      exp_rsp[k]  = '0;
      exp_p0[k]   = 1'b0;
      exp_p1[k]   = 1'b0;
      exp_busy[k] = 1'b0;
      head[k]     = nacc;
    end
  endtask

  task automatic checkAll();
    er0 = 1'b0;
    er1 = 1'b0;
    if (req0_valid && req1_valid) begin
      er0 = (last_id == 1'b1);
      er1 = (last_id == 1'b0);
    end else begin
      er0 = req0_valid;
      er1 = req1_valid;
    end
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("L%0d_req0_ready", lat_of(k)), 80'(o_r0[k]), 80'(er0));
      checkOutput($sformatf("L%0d_req1_ready", lat_of(k)), 80'(o_r1[k]), 80'(er1));
      checkOutput($sformatf("L%0d_rsp0_valid", lat_of(k)), 80'(o_p0[k]), 80'(exp_p0[k]));
      checkOutput($sformatf("L%0d_rsp1_valid", lat_of(k)), 80'(o_p1[k]), 80'(exp_p1[k]));
      checkOutput($sformatf("L%0d_busy", lat_of(k)), 80'(o_busy[k]), 80'(exp_busy[k]));
      checkOutput($sformatf("L%0d_lut_angle", lat_of(k)), 80'(o_ang[k]), 80'(exp_ang));
      checkOutput($sformatf("L%0d_rsp_data", lat_of(k)), o_rsp[k], exp_rsp[k]);
    end
  endtask

  task automatic modelEdge();
    cyc++;
    acc0 = er0 && req0_valid;
    acc1 = er1 && req1_valid;
    if (acc0 || acc1) begin
      acc_cyc[nacc] = cyc;
      acc_id[nacc]  = acc1;
      acc_ang[nacc] = acc1 ? req1_angle : req0_angle;
      exp_ang       = acc_ang[nacc];
      last_id       = acc1;
      nacc++;
    end
    for (int k = 0; k < 3; k++) begin
      exp_p0[k] = 1'b0;
      exp_p1[k] = 1'b0;
      if (head[k] < nacc && acc_cyc[head[k]] + lat_of(k) + 1 == cyc) begin
        exp_p0[k]  = !acc_id[head[k]];
        exp_p1[k]  = acc_id[head[k]];
        exp_rsp[k] = lut_f(acc_ang[head[k]]);
        head[k]++;
      end
      exp_busy[k] = (head[k] < nacc);
    end
  endtask

  // One clock: drive inputs, check at the falling edge, advance the model.
  task automatic applyStimulus(input bit v0, input logic [9:0] a0,
                               input bit v1, input logic [9:0] a1);
    req0_valid = v0;
    req0_angle = a0;
    req1_valid = v1;
    req1_angle = a1;
    @(negedge clk);
    checkAll();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic doReset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b1;
    #1;
    resetModel();
    checkAll();
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [9:0] pickAngle();
    case ($urandom_range(0, 7))
      0: return 10'd0;
      1: return 10'd256;
      2: return 10'd512;
      3: return 10'd768;
      4: return 10'd128;
      default: return 10'($urandom_range(0, 1023));
    endcase
  endfunction

  initial begin : stim
    bit         v0, v1;
    logic [9:0] a0, a1;
    resetModel();
    doReset();

    applyStimulus(1'b1, 10'd128, 1'b0, 10'd0);
    repeat (6) applyStimulus(1'b0, 10'd0, 1'b0, 10'd0);

    doReset();
    repeat (6) applyStimulus(1'b1, 10'd10, 1'b1, 10'd20);
    repeat (6) applyStimulus(1'b0, 10'd0, 1'b0, 10'd0);

    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 10'd0, 1'b1, 10'(i));
    repeat (7) applyStimulus(1'b0, 10'd0, 1'b0, 10'd0);

    applyStimulus(1'b1, 10'd256, 1'b0, 10'd0);
    applyStimulus(1'b1, 10'd0, 1'b0, 10'd0);
    repeat (6) applyStimulus(1'b0, 10'd0, 1'b0, 10'd0);

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 10'(100 + i), 1'b0, 10'd0);
    applyStimulus(1'b0, 10'd0, 1'b0, 10'd0);
    doReset();
    repeat (6) applyStimulus(1'b0, 10'd0, 1'b0, 10'd0);
    applyStimulus(1'b1, 10'd300, 1'b1, 10'd400);
    applyStimulus(1'b0, 10'd0, 1'b1, 10'd400);
    repeat (6) applyStimulus(1'b0, 10'd0, 1'b0, 10'd0);

    v0 = 1'b0; v1 = 1'b0; a0 = '0; a1 = '0;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        doReset();
        v0 = 1'b0;
        v1 = 1'b0;
      end
      applyStimulus(v0, a0, v1, a1);
      if (!v0 || acc0) begin
        v0 = ($urandom_range(0, 3) != 0);
        a0 = pickAngle();
      end
      if (!v1 || acc1) begin
        v1 = ($urandom_range(0, 2) != 0);
        a1 = pickAngle();
      end
    end
    repeat (8) applyStimulus(1'b0, 10'd0, 1'b0, 10'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
